// File: rtl/pair_stream_arbiter_if.sv
// Handshake bundle between the two source channels, the arbiter and the
// downstream 2:1 mux.
//   a_valid/a_data/a_ready : channel A valid/ready source
//   b_valid/b_data/b_ready : channel B valid/ready source
//   mux_a/mux_b/mux_s      : registered mux operands and select (0 = A, 1 = B)
//   out_valid/out_ready    : output stage handshake toward the mux consumer
interface pair_stream_arbiter_if;
  localparam int unsigned DW = 2;

  logic          a_valid;
  logic [DW-1:0] a_data;
  logic          a_ready;
  logic          b_valid;
  logic [DW-1:0] b_data;
  logic          b_ready;
  logic [DW-1:0] mux_a;
  logic [DW-1:0] mux_b;
  logic          mux_s;
  logic          out_valid;
  logic          out_ready;

  // Traffic side: the sources and the downstream consumer.
  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, mux_a, mux_b, mux_s, out_valid
  );

  // Arbiter side.
  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, mux_a, mux_b, mux_s, out_valid
  );
endinterface

// File: rtl/pair_stream_arbiter.sv
// Round-robin arbiter with burst allowance feeding a 2-bit 2:1 mux.
// Accepts one word per cycle from channel A or B into a one-deep output
// stage that drives the mux operands/select, so the mux output is the
// arbitrated stream.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of pair_stream_arbiter_if (sources, mux, downstream)
// BURST (1..3): consecutive grants allowed to one channel under contention.
module pair_stream_arbiter #(
  parameter int unsigned BURST = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pair_stream_arbiter_if.slave  bus
);

  localparam int unsigned DW = 2;
  localparam int unsigned CW = 2;
  localparam logic [CW-1:0] BURST_CNT = CW'(BURST);
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] mux_a_q, mux_a_d;
  logic [DW-1:0] mux_b_q, mux_b_d;
  logic          mux_s_q, mux_s_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic grant_vld_c;
  logic grant_sel_c;
  logic load_c;
  logic a_ready_c;
  logic b_ready_c;

  // Grant: lone requester wins; under contention stay on last until the
  // burst allowance is used up, then hand over.
  always_comb begin
    grant_vld_c = bus.a_valid | bus.b_valid;
    grant_sel_c = SEL_A;
    if (bus.a_valid && bus.b_valid) begin
      grant_sel_c = (cnt_q < BURST_CNT) ? last_q : ~last_q;
    end else if (bus.b_valid) begin
      grant_sel_c = SEL_B;
    end
  end

  // Output stage can take a word when empty or draining this cycle.
  assign load_c    = ~out_valid_q | bus.out_ready;
  assign a_ready_c = rst_n & load_c & grant_vld_c & (grant_sel_c == SEL_A);
  assign b_ready_c = rst_n & load_c & grant_vld_c & (grant_sel_c == SEL_B);

  // Next state of the output stage and arbitration history.
  always_comb begin
    out_valid_d = out_valid_q;
    mux_a_d     = mux_a_q;
    mux_b_d     = mux_b_q;
    mux_s_d     = mux_s_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    if (a_ready_c || b_ready_c) begin
      out_valid_d = 1'b1;
      mux_s_d     = grant_sel_c;
      // Only the granted operand is rewritten; the other one holds.
      if (grant_sel_c == SEL_A) begin
        mux_a_d = bus.a_data;
      end else begin
        mux_b_d = bus.b_data;
      end
      if (grant_sel_c != last_q) begin
        last_d = grant_sel_c;
        cnt_d  = CW'(1);
      end else if (cnt_q < BURST_CNT) begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset makes B the last winner so A wins first contention.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      mux_a_q     <= '0;
      mux_b_q     <= '0;
      mux_s_q     <= SEL_A;
      last_q      <= SEL_B;
      cnt_q       <= BURST_CNT;
    end else begin
      out_valid_q <= out_valid_d;
      mux_a_q     <= mux_a_d;
      mux_b_q     <= mux_b_d;
      mux_s_q     <= mux_s_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.a_ready   = a_ready_c;
  assign bus.b_ready   = b_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.mux_a     = mux_a_q;
  assign bus.mux_b     = mux_b_q;
  assign bus.mux_s     = mux_s_q;

endmodule

// File: tb/tb_pair_stream_arbiter.sv
// Bench for pair_stream_arbiter: one instance with BURST=1 and one with
// BURST=2, driven by directed sequences and then random traffic, checked
// against a behavioural model of the arbitration rules.
module tb_pair_stream_arbiter;

  logic clk;
  logic rst_n;

  logic       av[2];
  logic [1:0] ad[2];
  logic       bv[2];
  logic [1:0] bd[2];
  logic       ordy[2];
  logic       ar[2];
  logic       br[2];
  logic [1:0] ma[2];
  logic [1:0] mb[2];
  logic       ms[2];
  logic       ov[2];

  pair_stream_arbiter_if bus0 ();
  pair_stream_arbiter_if bus1 ();

  assign bus0.a_valid   = av[0];
  assign bus0.a_data    = ad[0];
  assign bus0.b_valid   = bv[0];
  assign bus0.b_data    = bd[0];
  assign bus0.out_ready = ordy[0];
  assign bus1.a_valid   = av[1];
  assign bus1.a_data    = ad[1];
  assign bus1.b_valid   = bv[1];
  assign bus1.b_data    = bd[1];
  assign bus1.out_ready = ordy[1];

  assign ar[0] = bus0.a_ready;
  assign br[0] = bus0.b_ready;
  assign ma[0] = bus0.mux_a;
  assign mb[0] = bus0.mux_b;
  assign ms[0] = bus0.mux_s;
  assign ov[0] = bus0.out_valid;
  assign ar[1] = bus1.a_ready;
  assign br[1] = bus1.b_ready;
  assign ma[1] = bus1.mux_a;
  assign mb[1] = bus1.mux_b;
  assign ms[1] = bus1.mux_s;
  assign ov[1] = bus1.out_valid;

  pair_stream_arbiter #(.BURST(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  pair_stream_arbiter #(.BURST(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Behavioural model per instance.
  int         burst[2];
  bit         m_ov[2];
  logic [1:0] m_a[2];
  logic [1:0] m_b[2];
  bit         m_s[2];
  logic [1:0] m_o[2];
  bit         m_last[2];
  int         m_run[2];

  // Source state: directed sequences or random held words.
  bit         rnd;
  bit         ordy_dir;
  logic [1:0] sa[8];
  logic [1:0] sb[8];
  int         na, nb;
  int         ia[2], ib[2];
  bit         pa[2], pb[2];
  logic [1:0] da[2], db[2];

  // Accepted words as {sel, data}, observed from the DUT handshakes.
  logic [2:0] lg0[$];
  logic [2:0] lg1[$];

  logic [2:0] exp_b1[6];
  logic [2:0] exp_b2[6];

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ov[k]   = 1'b0;
      m_a[k]    = 2'd0;
      m_b[k]    = 2'd0;
      m_s[k]    = 1'b0;
      m_o[k]    = 2'd0;
      m_last[k] = 1'b1;
      m_run[k]  = burst[k];
    end
  endtask

  task automatic drive();
    for (int k = 0; k < 2; k++) begin
      if (rnd) begin
        if (!pa[k] && $urandom_range(0, 2) != 0) begin
          pa[k] = 1'b1;
          da[k] = 2'($urandom_range(0, 3));
        end
        if (!pb[k] && $urandom_range(0, 2) != 0) begin
          pb[k] = 1'b1;
          db[k] = 2'($urandom_range(0, 3));
        end
        av[k]   = pa[k];
        ad[k]   = da[k];
        bv[k]   = pb[k];
        bd[k]   = db[k];
        ordy[k] = ($urandom_range(0, 3) != 0);
      end else begin
        av[k]   = (ia[k] < na);
        ad[k]   = sa[(ia[k] < na) ? ia[k] : 0];
        bv[k]   = (ib[k] < nb);
        bd[k]   = sb[(ib[k] < nb) ? ib[k] : 0];
        ordy[k] = ordy_dir;
      end
    end
  endtask

  // One clock: check readys against the model, clock, advance model and
  // sources, then check registered outputs.
  task automatic cyc();
    bit ea[2];
    bit eb[2];
    #1;
    for (int k = 0; k < 2; k++) begin
      bit gs;
      bit ld;
      if (av[k] && bv[k]) gs = (m_run[k] < burst[k]) ? m_last[k] : !m_last[k];
      else                gs = bv[k];
      ld    = !m_ov[k] || ordy[k];
      ea[k] = rst_n && ld && av[k] && !gs;
      eb[k] = rst_n && ld && bv[k] && gs;
      chk($sformatf("a_ready%0d", k), 4'(ar[k]), 4'(ea[k]));
      chk($sformatf("b_ready%0d", k), 4'(br[k]), 4'(eb[k]));
      if (ar[k] && av[k]) begin
        if (k == 0) lg0.push_back({1'b0, ad[k]}); else lg1.push_back({1'b0, ad[k]});
      end else if (br[k] && bv[k]) begin
        if (k == 0) lg0.push_back({1'b1, bd[k]}); else lg1.push_back({1'b1, bd[k]});
      end
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (ea[k] || eb[k]) begin
          bit c;
          c       = eb[k];
          m_ov[k] = 1'b1;
          m_s[k]  = c;
          if (c) begin m_b[k] = bd[k]; m_o[k] = bd[k]; end
          else   begin m_a[k] = ad[k]; m_o[k] = ad[k]; end
          if (c != m_last[k]) begin
            m_last[k] = c;
            m_run[k]  = 1;
          end else begin
            m_run[k] = (m_run[k] + 1 > burst[k]) ? burst[k] : m_run[k] + 1;
          end
          if (ea[k]) begin if (rnd) pa[k] = 1'b0; else ia[k]++; end
          if (eb[k]) begin if (rnd) pb[k] = 1'b0; else ib[k]++; end
        end else if (m_ov[k] && ordy[k]) begin
          m_ov[k] = 1'b0;
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("out_valid%0d", k), 4'(ov[k]), 4'(m_ov[k]));
      chk($sformatf("mux_s%0d", k), 4'(ms[k]), 4'(m_s[k]));
      chk($sformatf("mux_a%0d", k), 4'(ma[k]), 4'(m_a[k]));
      chk($sformatf("mux_b%0d", k), 4'(mb[k]), 4'(m_b[k]));
      if (m_ov[k]) chk($sformatf("mux_o%0d", k), 4'(ms[k] ? mb[k] : ma[k]), 4'(m_o[k]));
    end
  endtask

  task automatic src_reset();
    for (int k = 0; k < 2; k++) begin
      ia[k] = 0;
      ib[k] = 0;
      pa[k] = 1'b0;
      pb[k] = 1'b0;
      da[k] = 2'd0;
      db[k] = 2'd0;
    end
  endtask

  initial begin
    logic [2:0] t;
    checks   = 0;
    failures = 0;
    burst[0] = 1;
    burst[1] = 2;
    exp_b1   = '{3'b001, 3'b100, 3'b010, 3'b111, 3'b011, 3'b110};
    exp_b2   = '{3'b001, 3'b010, 3'b100, 3'b111, 3'b011, 3'b110};
    for (int i = 0; i < 8; i++) begin sa[i] = 2'd0; sb[i] = 2'd0; end
    rnd      = 1'b0;
    ordy_dir = 1'b1;
    na = 0;
    nb = 0;
    src_reset();
    model_reset();

    // Reset state.
    rst_n = 1'b0;
    drive();
    @(posedge clk);
    #1;
    drive();
    cyc();

    // Single A word lands on the mux one cycle later; mux_b untouched.
    rst_n = 1'b1;
    sa[0] = 2'b10;
    na = 1;
    drive();
    cyc();
    chk("first_mux_a", 4'(ma[0]), 4'b0010);
    chk("first_mux_b", 4'(mb[0]), 4'b0000);
    drive();
    cyc();

    // Continuous contention from a fresh reset: BURST=1 alternates, BURST=2 pairs.
    rst_n = 1'b0;
    drive();
    cyc();
    rst_n = 1'b1;
    src_reset();
    sa[0] = 2'd1; sa[1] = 2'd2; sa[2] = 2'd3;
    sb[0] = 2'd0; sb[1] = 2'd3; sb[2] = 2'd2;
    na = 3;
    nb = 3;
    lg0.delete();
    lg1.delete();
    for (int i = 0; i < 7; i++) begin drive(); cyc(); end
    chk("seq_b1_len", 4'(lg0.size()), 4'd6);
    chk("seq_b2_len", 4'(lg1.size()), 4'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < lg0.size()) chk($sformatf("seq_b1_%0d", i), 4'(lg0[i]), 4'(exp_b1[i]));
      if (i < lg1.size()) chk($sformatf("seq_b2_%0d", i), 4'(lg1[i]), 4'(exp_b2[i]));
    end

    // Stall: output held, no readys, then load on the release cycle.
    src_reset();
    for (int i = 0; i < 8; i++) begin sa[i] = 2'(i); sb[i] = 2'(7 - i); end
    na = 8;
    nb = 8;
    ordy_dir = 1'b1;
    drive();
    cyc();
    ordy_dir = 1'b0;
    for (int i = 0; i < 3; i++) begin drive(); cyc(); end
    ordy_dir = 1'b1;
    drive();
    cyc();
    chk("release_valid", 4'(ov[0]), 4'd1);

    // Lone B stream is never throttled; A then wins the first contention.
    rst_n = 1'b0;
    na = 0;
    nb = 0;
    drive();
    cyc();
    rst_n = 1'b1;
    src_reset();
    sb[0] = 2'd3; sb[1] = 2'd1; sb[2] = 2'd2; sb[3] = 2'd0; sb[4] = 2'd3;
    nb = 5;
    lg0.delete();
    lg1.delete();
    for (int i = 0; i < 5; i++) begin drive(); cyc(); end
    chk("b_only_cnt0", 4'(lg0.size()), 4'd5);
    chk("b_only_cnt1", 4'(lg1.size()), 4'd5);
    sa[0] = 2'd2;
    na = 1;
    sb[5] = 2'd1;
    nb = 6;
    drive();
    cyc();
    t = (lg0.size() > 0) ? lg0[lg0.size() - 1] : 3'b111;
    chk("after_b_sel0", 4'(t[2]), 4'd0);
    t = (lg1.size() > 0) ? lg1[lg1.size() - 1] : 3'b111;
    chk("after_b_sel1", 4'(t[2]), 4'd0);

    // Reset while holding a word with another A word pending.
    src_reset();
    sa[0] = 2'd1; sa[1] = 2'd3;
    na = 2;
    nb = 0;
    drive();
    cyc();
    rst_n = 1'b0;
    drive();
    cyc();
    chk("midreset_valid", 4'(ov[0]), 4'd0);
    chk("midreset_a", 4'(ma[0]), 4'd0);
    rst_n = 1'b1;
    src_reset();
    sa[0] = 2'd2;
    sb[0] = 2'd1;
    na = 1;
    nb = 1;
    lg0.delete();
    lg1.delete();
    drive();
    cyc();
    t = (lg0.size() > 0) ? lg0[0] : 3'b111;
    chk("post_reset_first0", 4'(t), 4'b0010);
    t = (lg1.size() > 0) ? lg1[0] : 3'b111;
    chk("post_reset_first1", 4'(t), 4'b0010);

    // Random traffic with random back-pressure and occasional reset.
    src_reset();
    rnd = 1'b1;
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      drive();
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
